// File: rtl/clip_recorder_ctrl.sv
// ============================================================================
// clip_recorder_ctrl
// ----------------------------------------------------------------------------
// Record/playback controller for the voice-clip recorder. The sample memory
// is split into NUM_CLIPS fixed-length slots of SAMPLES_PER_CLIP samples.
// A free-running divider inside each operation produces one sample strobe
// every SAMPLE_DIV clock cycles; each strobe issues one memory write
// (RECORD) or one memory read (PLAY). A per-slot valid bit records which
// slots hold a complete, uninterrupted recording.
//
// Configuration macro:
//   LOOP_PLAY_EN  defined   -> playback wraps to the first sample of the slot
//                              and repeats until stop; no done pulse for PLAY.
//                 undefined -> playback ends after one pass (default build).
//
// Ports:
//   clock       in   1          system clock, rising edge
//   reset       in   1          asynchronous active-high reset
//   record      in   1          start recording clip_sel (honoured in IDLE)
//   play        in   1          start playback of clip_sel (honoured in IDLE)
//   stop        in   1          abort the running operation
//   clip_sel    in   SEL_W      target slot
//   mem_addr    out  ADDR_W     slot*SAMPLES_PER_CLIP + sample index, 0 in IDLE
//   mem_we      out  1          one-cycle write strobe while recording
//   mem_re      out  1          one-cycle read strobe while playing
//   busy        out  1          operation in progress
//   recording   out  1          RECORD active
//   playing     out  1          PLAY active
//   done        out  1          one-cycle pulse after normal completion
//   err         out  1          one-cycle pulse after a rejected request
//   clip_valid  out  NUM_CLIPS  bit i set when slot i holds a complete clip
// ============================================================================
module clip_recorder_ctrl #(
    parameter int NUM_CLIPS        = 4,
    parameter int SAMPLES_PER_CLIP = 16000,
    parameter int SAMPLE_DIV       = 6250,
    parameter int ADDR_W           = 16,
    parameter int SEL_W            = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 record,
    input  logic                 play,
    input  logic                 stop,
    input  logic [SEL_W-1:0]     clip_sel,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic                 mem_we,
    output logic                 mem_re,
    output logic                 busy,
    output logic                 recording,
    output logic                 playing,
    output logic                 done,
    output logic                 err,
    output logic [NUM_CLIPS-1:0] clip_valid
);

    // Counter widths follow their terminal counts; a limit of 1 still needs a bit.
    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int CNT_W = (SAMPLES_PER_CLIP > 1) ? $clog2(SAMPLES_PER_CLIP) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(SAMPLES_PER_CLIP - 1);
    localparam logic [ADDR_W-1:0] CLIP_SPAN  = ADDR_W'(SAMPLES_PER_CLIP);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECORD = 2'd1,
        ST_PLAY   = 2'd2
    } state_t;

    state_t                 state_r;
    state_t                 state_next_s;
    logic [SEL_W-1:0]       slot_r;
    logic [SEL_W-1:0]       slot_next_s;
    logic [DIV_W-1:0]       div_cnt_r;
    logic [DIV_W-1:0]       div_cnt_next_s;
    logic [CNT_W-1:0]       sample_cnt_r;
    logic [CNT_W-1:0]       sample_cnt_next_s;
    logic [NUM_CLIPS-1:0]   clip_valid_r;
    logic [NUM_CLIPS-1:0]   clip_valid_next_s;
    logic                   done_r;
    logic                   done_next_s;
    logic                   err_r;
    logic                   err_next_s;

    logic                   strobe_s;
    logic                   last_sample_s;
    logic                   sel_in_range_s;
    logic                   sel_has_clip_s;
    logic                   active_s;

    // Sample strobe and end-of-clip detection from the two counters.
    always_comb begin
        strobe_s      = (div_cnt_r == DIV_LAST);
        last_sample_s = (sample_cnt_r == CNT_LAST);
        active_s      = (state_r != ST_IDLE);
    end

    // Decode clip_sel against the slot count without a constant-range compare,
    // so NUM_CLIPS < 2**SEL_W and NUM_CLIPS == 2**SEL_W are handled alike.
    always_comb begin
        sel_in_range_s = 1'b0;
        sel_has_clip_s = 1'b0;
        for (int i = 0; i < NUM_CLIPS; i++) begin
            if (clip_sel == SEL_W'(i)) begin
                sel_in_range_s = 1'b1;
                sel_has_clip_s = clip_valid_r[i];
            end else begin
                sel_in_range_s = sel_in_range_s;
                sel_has_clip_s = sel_has_clip_s;
            end
        end
    end

    // Next-state, counter, valid-bit and pulse logic for the controller FSM.
    always_comb begin
        state_next_s      = state_r;
        slot_next_s       = slot_r;
        div_cnt_next_s    = div_cnt_r;
        sample_cnt_next_s = sample_cnt_r;
        clip_valid_next_s = clip_valid_r;
        done_next_s       = 1'b0;
        err_next_s        = 1'b0;

        case (state_r)
            ST_IDLE: begin
                div_cnt_next_s    = '0;
                sample_cnt_next_s = '0;
                if (record) begin
                    // record takes priority over a simultaneous play
                    if (sel_in_range_s) begin
                        state_next_s = ST_RECORD;
                        slot_next_s  = clip_sel;
                        // the slot is no longer trustworthy once overwriting starts
                        for (int i = 0; i < NUM_CLIPS; i++) begin
                            if (clip_sel == SEL_W'(i)) begin
                                clip_valid_next_s[i] = 1'b0;
                            end else begin
                                clip_valid_next_s[i] = clip_valid_r[i];
                            end
                        end
                    end else begin
                        err_next_s = 1'b1;
                    end
                end else if (play) begin
                    if (sel_in_range_s && sel_has_clip_s) begin
                        state_next_s = ST_PLAY;
                        slot_next_s  = clip_sel;
                    end else begin
                        err_next_s = 1'b1;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end

            ST_RECORD, ST_PLAY: begin
                if (stop) begin
                    // abort beats a coincident last strobe: no done, slot stays invalid
                    state_next_s      = ST_IDLE;
                    div_cnt_next_s    = '0;
                    sample_cnt_next_s = '0;
                end else if (strobe_s) begin
                    div_cnt_next_s = '0;
                    if (last_sample_s) begin
                        sample_cnt_next_s = '0;
                        if (state_r == ST_RECORD) begin
                            state_next_s = ST_IDLE;
                            done_next_s  = 1'b1;
                            clip_valid_next_s[slot_r] = 1'b1;
                        end else begin
`ifdef LOOP_PLAY_EN
                            // wrap to the start of the slot and keep playing
                            state_next_s = ST_PLAY;
`else
                            state_next_s = ST_IDLE;
                            done_next_s  = 1'b1;
`endif
                        end
                    end else begin
                        sample_cnt_next_s = sample_cnt_r + CNT_W'(1);
                    end
                end else begin
                    div_cnt_next_s = div_cnt_r + DIV_W'(1);
                end
            end

            default: begin
                state_next_s      = ST_IDLE;
                div_cnt_next_s    = '0;
                sample_cnt_next_s = '0;
            end
        endcase
    end

    // State, counter and flag registers; reset invalidates every clip.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            slot_r       <= '0;
            div_cnt_r    <= '0;
            sample_cnt_r <= '0;
            clip_valid_r <= '0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            slot_r       <= slot_next_s;
            div_cnt_r    <= div_cnt_next_s;
            sample_cnt_r <= sample_cnt_next_s;
            clip_valid_r <= clip_valid_next_s;
            done_r       <= done_next_s;
            err_r        <= err_next_s;
        end
    end

    // Memory interface: strobes are suppressed in the cycle stop is seen so an
    // aborted operation never touches one more sample.
    always_comb begin
        mem_we = (state_r == ST_RECORD) && strobe_s && !stop;
        mem_re = (state_r == ST_PLAY) && strobe_s && !stop;
        if (active_s) begin
            mem_addr = (ADDR_W'(slot_r) * CLIP_SPAN) + ADDR_W'(sample_cnt_r);
        end else begin
            mem_addr = '0;
        end
    end

    // Status outputs decoded straight from registers.
    always_comb begin
        busy       = active_s;
        recording  = (state_r == ST_RECORD);
        playing    = (state_r == ST_PLAY);
        done       = done_r;
        err        = err_r;
        clip_valid = clip_valid_r;
    end

endmodule

// File: tb/tb_clip_recorder_ctrl.sv
// Self-checking bench for clip_recorder_ctrl with a small configuration
// (4 slots, 8 samples per clip, 4 cycles per sample). A reference model
// tracks each operation as "mode, slot, cycles elapsed since entry" and
// derives strobes and addresses arithmetically from that elapsed count.
module tb_clip_recorder_ctrl;

    localparam int NC  = 4;
    localparam int SPC = 8;
    localparam int DIV = 4;
    localparam int AW  = 5;
    localparam int SW  = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic          record;
    logic          play;
    logic          stop;
    logic [SW-1:0] clip_sel;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic          mem_re;
    logic          busy;
    logic          recording;
    logic          playing;
    logic          done;
    logic          err;
    logic [NC-1:0] clip_valid;

    clip_recorder_ctrl #(
        .NUM_CLIPS(NC), .SAMPLES_PER_CLIP(SPC), .SAMPLE_DIV(DIV), .ADDR_W(AW), .SEL_W(SW)
    ) dut (
        .clock(clock), .reset(reset), .record(record), .play(play), .stop(stop),
        .clip_sel(clip_sel), .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re),
        .busy(busy), .recording(recording), .playing(playing), .done(done),
        .err(err), .clip_valid(clip_valid)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // reference model: 0 idle, 1 record, 2 play
    int            m_mode;
    int            m_slot;
    int            m_t;
    logic [NC-1:0] m_valid;
    logic          m_done;
    logic          m_err;

    // per-phase tallies observed on the DUT
    int we_cnt, re_cnt, done_cnt, err_cnt, busy_cnt, rec_cyc, play_cyc;
    int first_addr, last_addr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] dut_outs();
        return {16'd0, mem_addr, mem_we, mem_re, busy, recording, playing, done, err, clip_valid};
    endfunction

    function automatic logic [31:0] exp_outs();
        logic          strobe;
        logic [AW-1:0] addr;
        strobe = (m_mode != 0) && ((m_t % DIV) == DIV - 1) && !stop;
        addr   = (m_mode != 0) ? AW'(m_slot * SPC + m_t / DIV) : '0;
        return {16'd0, addr, (m_mode == 1) && strobe, (m_mode == 2) && strobe,
                m_mode != 0, m_mode == 1, m_mode == 2, m_done, m_err, m_valid};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_slot = 0; m_t = 0; m_valid = '0; m_done = 1'b0; m_err = 1'b0;
    endtask

    // advance the model across one rising edge using the current inputs
    task automatic model_step();
        int sel;
        sel    = int'(clip_sel);
        m_done = 1'b0;
        m_err  = 1'b0;
        if (m_mode == 0) begin
            if (record) begin
                if (sel >= NC) m_err = 1'b1;
                else begin m_mode = 1; m_slot = sel; m_t = 0; m_valid[sel] = 1'b0; end
            end else if (play) begin
                if (sel >= NC || !m_valid[sel]) m_err = 1'b1;
                else begin m_mode = 2; m_slot = sel; m_t = 0; end
            end
        end else if (stop) begin
            m_mode = 0;
        end else if (m_t == SPC * DIV - 1) begin
            if (m_mode == 1) begin
                m_valid[m_slot] = 1'b1; m_done = 1'b1; m_mode = 0;
            end else begin
`ifdef LOOP_PLAY_EN
                m_t = 0;
`else
                m_done = 1'b1; m_mode = 0;
`endif
            end
        end else begin
            m_t++;
        end
    endtask

    task automatic clear_tallies();
        we_cnt = 0; re_cnt = 0; done_cnt = 0; err_cnt = 0; busy_cnt = 0;
        rec_cyc = 0; play_cyc = 0; first_addr = -1; last_addr = -1;
    endtask

    // one clock cycle: drive, compare all outputs against the model, tally, step
    task automatic cycle(input logic r, input logic p, input logic s, input int sel, input string tag);
        @(negedge clock);
        record = r; play = p; stop = s; clip_sel = SW'(sel);
        #1;
        chk(tag, dut_outs(), exp_outs());
        if (mem_we || mem_re) begin
            if (first_addr < 0) first_addr = int'(mem_addr);
            last_addr = int'(mem_addr);
        end
        if (mem_we) we_cnt++;
        if (mem_re) re_cnt++;
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (busy) busy_cnt++;
        if (recording) rec_cyc++;
        if (playing) play_cyc++;
        model_step();
    endtask

    task automatic idle_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 0, tag);
    endtask

    // reset asserted mid-cycle: outputs must clear without waiting for an edge
    task automatic hit_reset(input string tag);
        @(negedge clock);
        record = 1'b0; play = 1'b0; stop = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk(tag, dut_outs(), 32'd0);
        model_reset();
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; record = 1'b0; play = 1'b0; stop = 1'b0; clip_sel = '0;
        model_reset();
        clear_tallies();
        #1;
        chk("reset_state", dut_outs(), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        idle_cycles(2, "idle");

        // record clip 2 to completion
        clear_tallies();
        cycle(1'b1, 1'b0, 1'b0, 2, "rec2_req");
        idle_cycles(40, "rec2_run");
        chk("rec2_we_cnt", we_cnt, 8);
        chk("rec2_first_addr", first_addr, 16);
        chk("rec2_last_addr", last_addr, 23);
        chk("rec2_done_cnt", done_cnt, 1);
        chk("rec2_busy_cyc", busy_cnt, SPC * DIV);
        chk("rec2_valid", clip_valid, 4'b0100);

        // play clip 2, then request the empty clip 1
        clear_tallies();
        cycle(1'b0, 1'b1, 1'b0, 2, "play2_req");
        idle_cycles(40, "play2_run");
        chk("play2_re_cnt", re_cnt, 8);
        chk("play2_first_addr", first_addr, 16);
        chk("play2_last_addr", last_addr, 23);
        chk("play2_we_cnt", we_cnt, 0);
`ifndef LOOP_PLAY_EN
        chk("play2_done_cnt", done_cnt, 1);
`endif
`ifdef LOOP_PLAY_EN
        cycle(1'b0, 1'b0, 1'b1, 0, "play2_stop");
`endif
        clear_tallies();
        cycle(1'b0, 1'b1, 1'b0, 1, "play1_req");
        idle_cycles(3, "play1_after");
        chk("play1_err_cnt", err_cnt, 1);
        chk("play1_busy_cnt", busy_cnt, 0);

        // record clip 0, stop after three writes
        clear_tallies();
        cycle(1'b1, 1'b0, 1'b0, 0, "rec0_req");
        for (int i = 0; i < 100 && we_cnt < 3; i++) cycle(1'b0, 1'b0, 1'b0, 0, "rec0_run");
        chk("rec0_we_before_stop", we_cnt, 3);
        cycle(1'b0, 1'b0, 1'b1, 0, "rec0_stop");
        idle_cycles(3, "rec0_after");
        chk("rec0_done_cnt", done_cnt, 0);
        chk("rec0_we_total", we_cnt, 3);
        chk("rec0_valid0", clip_valid[0], 1'b0);
        chk("rec0_busy", busy, 1'b0);

        // record and play on the same edge: record wins
        clear_tallies();
        cycle(1'b1, 1'b1, 1'b0, 3, "tie_req");
        idle_cycles(40, "tie_run");
        chk("tie_rec_cyc", rec_cyc, SPC * DIV);
        chk("tie_play_cyc", play_cyc, 0);
        chk("tie_valid", clip_valid, 4'b1100);

        // re-record clip 3 and reset after five writes
        clear_tallies();
        cycle(1'b1, 1'b0, 1'b0, 3, "rerec_req");
        for (int i = 0; i < 100 && we_cnt < 5; i++) cycle(1'b0, 1'b0, 1'b0, 0, "rerec_run");
        chk("rerec_we_before_reset", we_cnt, 5);
        hit_reset("rerec_async_reset");
        idle_cycles(2, "post_reset");
        chk("post_reset_valid", clip_valid, 4'b0000);

`ifdef LOOP_PLAY_EN
        // looping playback: 20 strobes, addresses wrap within the slot
        cycle(1'b1, 1'b0, 1'b0, 2, "loop_rec_req");
        idle_cycles(40, "loop_rec_run");
        clear_tallies();
        cycle(1'b0, 1'b1, 1'b0, 2, "loop_play_req");
        for (int i = 0; i < 200 && re_cnt < 20; i++) cycle(1'b0, 1'b0, 1'b0, 0, "loop_play_run");
        chk("loop_re_cnt", re_cnt, 20);
        chk("loop_last_addr", last_addr, 16 + (19 % SPC));
        chk("loop_done_cnt", done_cnt, 0);
        cycle(1'b0, 1'b0, 1'b1, 0, "loop_stop");
        idle_cycles(2, "loop_after");
        chk("loop_busy", busy, 1'b0);
`endif

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 999) == 0) begin
                hit_reset("rand_async_reset");
            end else begin
                cycle($urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
                      $urandom_range(0, 99) == 0, int'($urandom_range(0, NC - 1)), "rand");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
